// File: rtl/demux8_collect.sv
// demux8_collect: serial-to-parallel collector. This is the inverse of an 8:1 mux.
// A bit that is accepted while sel=k is stored at out_data[k].
// Compile-time option: define PARITY_EN to add a ninth, even-parity bit to each
// frame. With PARITY_EN the par_err output is present.
module demux8_collect (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic [2:0] sel,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] frame_cnt
`ifdef PARITY_EN
    ,
    output logic       par_err
`endif
);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PARITY  = 2'd1,
        HOLD    = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd2
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] out_data_q, out_data_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] shadow_ins;
    logic       accept;
`ifdef PARITY_EN
    logic       par_err_q, par_err_d;
`endif

    // Ready is masked while reset is held, so nothing is offered as accepted during reset.
    always_comb begin
        in_ready  = rst & (state_q != HOLD);
        out_valid = (state_q == HOLD);
        accept    = in_valid & in_ready;
    end

    // This is the shadow byte with the current input bit placed at position sel.
    always_comb begin
        shadow_ins        = shadow_q;
        shadow_ins[sel_q] = in_bit;
    end

    // Next-state logic. A clear overrides everything else; it resets all state except the frame counter.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        frame_cnt_d = frame_cnt_q;
`ifdef PARITY_EN
        par_err_d   = par_err_q;
`endif
        if (clr) begin
            state_d    = COLLECT;
            sel_d      = 3'd0;
            shadow_d   = 8'h00;
            out_data_d = 8'h00;
`ifdef PARITY_EN
            par_err_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        shadow_d = shadow_ins;
                        sel_d    = sel_q + 3'd1;
                        if (sel_q == 3'd7) begin
`ifdef PARITY_EN
                            state_d    = PARITY;
`else
                            state_d    = HOLD;
                            out_data_d = shadow_ins;
`endif
                        end
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (accept) begin
                        out_data_d = shadow_q;
                        par_err_d  = ^{shadow_q, in_bit};
                        state_d    = HOLD;
                    end
                end
`endif
                HOLD: begin
                    if (out_ready) begin
                        state_d     = COLLECT;
                        sel_d       = 3'd0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = COLLECT;
                    sel_d   = 3'd0;
                end
            endcase
        end
    end

    // State registers. A low rst clears all state asynchronously, so any partial or held byte is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= COLLECT;
            sel_q       <= 3'd0;
            shadow_q    <= 8'h00;
            out_data_q  <= 8'h00;
            frame_cnt_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            shadow_q    <= shadow_d;
            out_data_q  <= out_data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef PARITY_EN
    // Parity error flag. It is captured together with out_data when the parity bit is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_demux8_collect.sv
// tb_demux8_collect: directed bench for demux8_collect.
// The bench keeps a transaction-level model: a queue of accepted bits and a held-byte flag.
// The model is compared with the DUT on every falling edge.
// Hand-computed literal checks pin the model to known answers.
// Define PARITY_EN to exercise the parity build.
`timescale 1ns/100ps
module tb_demux8_collect;

`ifdef PARITY_EN
    localparam int FRAME_LEN = 9;
`else
    localparam int FRAME_LEN = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic [2:0] sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] frame_cnt;
`ifdef PARITY_EN
    logic       par_err;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    // Model state.
    bit mBits[$];
    bit mHold = 1'b0;
    int mCnt = 0;
    int mOut = 0;
    int mPerr = 0;

    demux8_collect dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt)
`ifdef PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change at posedge+3. They stay stable through the falling edge and the next rising edge.
    task automatic applyStimulus(input logic v, input logic b, input logic ordy, input logic c);
        in_valid  = v;
        in_bit    = b;
        out_ready = ordy;
        clr       = c;
        @(posedge clk);
        #3;
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic pbit, input logic ordy);
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, data[k], ordy, 1'b0);
`ifdef PARITY_EN
        applyStimulus(1'b1, pbit, ordy, 1'b0);
`else
        if (pbit) begin end
`endif
    endtask

    // Model: whole frames are built from a bit queue. The byte value is the weighted sum of the bits.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mBits.delete();
            mHold = 1'b0;
            mCnt  = 0;
            mOut  = 0;
            mPerr = 0;
        end else if (clr) begin
            mBits.delete();
            mHold = 1'b0;
        end else if (mHold) begin
            if (out_ready) begin
                mHold = 1'b0;
                mCnt  = (mCnt + 1) % 256;
            end
        end else if (in_valid) begin
            mBits.push_back(in_bit);
            if (mBits.size() == FRAME_LEN) begin
                int v;
                int ones;
                v = 0;
                ones = 0;
                for (int k = 0; k < 8; k++) if (mBits[k]) v += (1 << k);
                for (int k = 0; k < FRAME_LEN; k++) if (mBits[k]) ones++;
                mOut  = v;
                mPerr = ones % 2;
                mHold = 1'b1;
                mBits.delete();
            end
        end
    end

    // Every falling edge, compare the DUT with the model.
    always @(negedge clk) begin
        checkOutput("in_ready", in_ready, rst && !mHold);
        checkOutput("out_valid", out_valid, mHold);
        checkOutput("sel", sel, mHold ? 0 : (mBits.size() % 8));
        checkOutput("frame_cnt", frame_cnt, mCnt);
        if (mHold) begin
            checkOutput("out_data", out_data, mOut);
`ifdef PARITY_EN
            checkOutput("par_err", par_err, mPerr);
`endif
        end
    end

    initial begin
        logic [7:0] b8;
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 8'h00);
        checkOutput("rst_sel", sel, 0);
        checkOutput("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b1;
        @(posedge clk);
        #3;
        checkOutput("post_rst_in_ready", in_ready, 1);

        // Bits 1,0,1,1,0,0,1,0 assemble to 8'h4D, and out_ready is high throughout.
        sendFrame(8'h4D, 1'b0, 1'b1);
        checkOutput("4D_valid", out_valid, 1);
        checkOutput("4D_data", out_data, 8'h4D);
        checkOutput("4D_model", mOut, 8'h4D);
        checkOutput("4D_cnt_before", frame_cnt, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("4D_valid_one_cycle", out_valid, 0);
        checkOutput("4D_cnt", frame_cnt, 1);

        // The consumer stalls for five cycles. Input bits offered during the hold are ignored.
        sendFrame(8'h4D, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, k[0], 1'b0, 1'b0);
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_data", out_data, 8'h4D);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("stall_release", out_valid, 0);
        checkOutput("stall_cnt", frame_cnt, 2);

        // in_valid alternates, so sel must advance only on the valid cycles.
        b8 = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, ~b8[k], 1'b1, 1'b0);
            applyStimulus(1'b1, b8[k], 1'b1, 1'b0);
            if (k == 2) checkOutput("gap_sel3", sel, 3);
        end
`ifdef PARITY_EN
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
`endif
        checkOutput("gap_data", out_data, 8'h3C);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("gap_cnt", frame_cnt, 3);

        // Four bits are aborted by a clear. The clear coincides with an accept, so that bit is dropped.
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("clr_pre_sel", sel, 4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("clr_sel", sel, 0);
        sendFrame(8'hA5, 1'b0, 1'b1);
        checkOutput("A5_data", out_data, 8'hA5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("A5_cnt", frame_cnt, 4);

        // A clear during the hold outranks out_ready. The byte is dropped and the count is kept.
        sendFrame(8'h81, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_hold_valid", out_valid, 0);
        checkOutput("clr_hold_cnt", frame_cnt, 4);

        // Reset is pulsed while a byte is held, and its effect must be immediate.
        sendFrame(8'h5A, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        checkOutput("async_rst_valid", out_valid, 0);
        checkOutput("async_rst_cnt", frame_cnt, 0);
        checkOutput("async_rst_sel", sel, 0);
        checkOutput("async_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Deliver 256 frames so that the frame counter wraps back to zero.
        for (int i = 0; i < 256; i++) begin
            b8 = i[7:0];
            sendFrame(b8, ^b8, 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 254) checkOutput("cnt_255", frame_cnt, 255);
        end
        checkOutput("cnt_wrap", frame_cnt, 0);

`ifdef PARITY_EN
        // 8'h4D has four ones, so a parity bit of 0 is correct and a parity bit of 1 is an error.
        sendFrame(8'h4D, 1'b0, 1'b0);
        checkOutput("par_ok", par_err, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h4D, 1'b1, 1'b0);
        checkOutput("par_bad", par_err, 1);
        checkOutput("par_bad_data", out_data, 8'h4D);
        checkOutput("par_bad_valid", out_valid, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
`endif

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
